// File: rtl/uart_cmd_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART command sequencer / TX scheduler.
//   state_e   : scheduler FSM states
//   cls_e     : request class that was served last (round-robin memory)
//   ACK_BYTE  : response byte for a completed operation
//   NAK_BYTE  : response byte for an invalid or timed-out operation
//   TLM_HDR   : first byte of every telemetry frame
//   opc_valid : opcode legality check
// ---------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RESP     = 2'd2,
    ST_TLM      = 2'd3
  } state_e;

  typedef enum logic {
    CLS_CMD = 1'b0,
    CLS_TLM = 1'b1
  } cls_e;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam logic [7:0] TLM_HDR  = 8'h5A;

  // Legal opcodes are 8'h01..8'h0F.
  function automatic logic opc_valid(input logic [7:0] opc);
    return (opc[7:4] == 4'h0) && (opc != 8'h00);
  endfunction

endpackage

// File: rtl/uart_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_sched_if
// Bundles every non-clock/reset signal of uart_cmd_sched.
//   Command side : cmd_rdy, cmd (in); clr_cmd_rdy (out)
//   UART TX side : tx_done (in); trmt, tx_data (out)
//   Executor     : op_done (in); op_vld, op_code, op_data (out)
//   Telemetry    : tlm_req, tlm_data (in); tlm_gnt (out)
//   Status       : busy (out)
// modport master : the scheduler's view
// modport slave  : the environment's view (UART_comm, executor, telemetry)
// ---------------------------------------------------------------------------
interface uart_cmd_sched_if;

  logic        cmd_rdy;
  logic [23:0] cmd;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        op_vld;
  logic [7:0]  op_code;
  logic [15:0] op_data;
  logic        op_done;
  logic        tlm_req;
  logic [15:0] tlm_data;
  logic        tlm_gnt;
  logic        busy;

  modport master (
    input  cmd_rdy, cmd, tx_done, op_done, tlm_req, tlm_data,
    output clr_cmd_rdy, trmt, tx_data, op_vld, op_code, op_data, tlm_gnt, busy
  );

  modport slave (
    output cmd_rdy, cmd, tx_done, op_done, tlm_req, tlm_data,
    input  clr_cmd_rdy, trmt, tx_data, op_vld, op_code, op_data, tlm_gnt, busy
  );

endinterface

// File: rtl/uart_cmd_sched_byte_sender.sv
// ---------------------------------------------------------------------------
// uart_byte_sender
// Sends one byte through the shared UART transmitter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : one-cycle request to send byte_i
//   byte_i      : byte to send, sampled with start_i
//   tx_done_i   : UART transmit-complete flag
//   trmt_o      : one-cycle pulse, the cycle after start_i
//   tx_data_o   : byte on the wire, held until the next start_i
//   sent_o      : combinational, high in the cycle the first tx_done rising
//                 edge after trmt_o is seen
// ---------------------------------------------------------------------------
module uart_byte_sender (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       tx_done_i,
  output logic       trmt_o,
  output logic [7:0] tx_data_o,
  output logic       sent_o
);

  logic       trmt_q, trmt_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       wait_q, wait_d;
  logic       tx_done_q;

  // Only an edge seen while a byte is in flight counts, so a tx_done that is
  // already high (or rises after an abort) never completes a new byte.
  assign sent_o = wait_q & tx_done_i & ~tx_done_q;

  always_comb begin
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    wait_d    = wait_q;
    if (start_i) begin
      tx_data_d = byte_i;
      trmt_d    = 1'b1;
      wait_d    = 1'b1;
    end else if (sent_o) begin
      wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      wait_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      wait_q    <= wait_d;
      tx_done_q <= tx_done_i;
    end
  end

  assign trmt_o    = trmt_q;
  assign tx_data_o = tx_data_q;

endmodule

// File: rtl/uart_cmd_sched.sv
// ---------------------------------------------------------------------------
// uart_cmd_sched
// Takes commands from UART_comm, validates and dispatches them to an
// executor, answers with ACK/NAK, and interleaves 3-byte telemetry frames on
// the same UART transmitter with round-robin arbitration.
//   TIMEOUT_CYC : max cycles op_vld may stay high without op_done
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : uart_cmd_sched_if.master (command, UART TX, executor,
//                 telemetry and busy signals)
// ---------------------------------------------------------------------------
module uart_cmd_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_sched_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Value of the counter in the last DISPATCH cycle before expiry.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  cls_e             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_code_q, op_code_d;
  logic [15:0]      op_data_q, op_data_d;
  logic             op_vld_q, op_vld_d;
  logic             clr_q, clr_d;
  logic             gnt_q, gnt_d;
  logic [15:0]      tlm_data_q, tlm_data_d;
  logic [1:0]       idx_q, idx_d;
  logic             start_q, start_d;
  logic [7:0]       snd_byte_q, snd_byte_d;

  logic             take_cmd;
  logic             take_tlm;
  logic             sent;
  logic             trmt;
  logic [7:0]       tx_data;

  // When both classes request, the one not served last wins.
  assign take_cmd = bus.cmd_rdy && (!bus.tlm_req || (last_q == CLS_TLM));
  assign take_tlm = bus.tlm_req && !take_cmd;

  uart_byte_sender u_sender (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_q),
    .byte_i    (snd_byte_q),
    .tx_done_i (bus.tx_done),
    .trmt_o    (trmt),
    .tx_data_o (tx_data),
    .sent_o    (sent)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    op_code_d  = op_code_q;
    op_data_d  = op_data_q;
    op_vld_d   = op_vld_q;
    clr_d      = 1'b0;
    gnt_d      = 1'b0;
    tlm_data_d = tlm_data_q;
    idx_d      = idx_q;
    start_d    = 1'b0;
    snd_byte_d = snd_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (take_cmd) begin
          op_code_d = bus.cmd[23:16];
          op_data_d = bus.cmd[15:0];
          clr_d     = 1'b1;
          if (opc_valid(bus.cmd[23:16])) begin
            state_d  = ST_DISPATCH;
            op_vld_d = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d    = ST_RESP;
            start_d    = 1'b1;
            snd_byte_d = NAK_BYTE;
          end
        end else if (take_tlm) begin
          gnt_d      = 1'b1;
          tlm_data_d = bus.tlm_data;
          state_d    = ST_TLM;
          idx_d      = 2'd0;
          start_d    = 1'b1;
          snd_byte_d = TLM_HDR;
        end
      end

      ST_DISPATCH: begin
        // Counter stops at TIMEOUT_CYC because DISPATCH is left at that point.
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.op_done) begin
          // Completion takes priority over a simultaneous expiry.
          op_vld_d   = 1'b0;
          state_d    = ST_RESP;
          start_d    = 1'b1;
          snd_byte_d = ACK_BYTE;
        end else if (cnt_q == CNT_LAST) begin
          op_vld_d   = 1'b0;
          state_d    = ST_RESP;
          start_d    = 1'b1;
          snd_byte_d = NAK_BYTE;
        end
      end

      ST_RESP: begin
        if (sent) begin
          state_d = ST_IDLE;
          last_d  = CLS_CMD;
        end
      end

      ST_TLM: begin
        if (sent) begin
          if (idx_q == 2'd2) begin
            state_d = ST_IDLE;
            last_d  = CLS_TLM;
          end else begin
            idx_d      = idx_q + 2'd1;
            start_d    = 1'b1;
            snd_byte_d = (idx_q == 2'd0) ? tlm_data_q[15:8] : tlm_data_q[7:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= CLS_TLM;
      cnt_q      <= '0;
      op_code_q  <= 8'h00;
      op_data_q  <= 16'h0000;
      op_vld_q   <= 1'b0;
      clr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      tlm_data_q <= 16'h0000;
      idx_q      <= 2'd0;
      start_q    <= 1'b0;
      snd_byte_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      op_code_q  <= op_code_d;
      op_data_q  <= op_data_d;
      op_vld_q   <= op_vld_d;
      clr_q      <= clr_d;
      gnt_q      <= gnt_d;
      tlm_data_q <= tlm_data_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      snd_byte_q <= snd_byte_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_q;
  assign bus.tlm_gnt     = gnt_q;
  assign bus.op_vld      = op_vld_q;
  assign bus.op_code     = op_code_q;
  assign bus.op_data     = op_data_q;
  assign bus.trmt        = trmt;
  assign bus.tx_data     = tx_data;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_sched
// Directed bench for uart_cmd_sched (TIMEOUT_CYC = 50). A small UART model
// captures each byte at trmt and raises tx_done BYTE_CYC cycles later;
// monitors count pulses and op_vld high time. Outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_cmd_sched;

  localparam int BYTE_CYC = 8;

  logic clk;
  logic rst_n;

  uart_cmd_sched_if bus ();

  uart_cmd_sched #(.TIMEOUT_CYC(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // UART model state
  int         ncnt = 0;
  int         trmt_cnt = 0;
  int         rise_cnt = 0;
  int         last_rise = -1000;
  int         stable_err = 0;
  logic [7:0] bytes[$];
  int         gaps[$];

  // monitor state
  int clr_cnt = 0;
  int gnt_cnt = 0;
  int vld_run = 0;
  int vld_total = 0;
  int last_vld_len = 0;

  int rd_idx = 0;

  initial begin
    int         busy_cnt;
    logic [7:0] cur;
    bit         chk_en;
    busy_cnt    = 0;
    cur         = 8'h00;
    chk_en      = 1'b0;
    bus.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      ncnt++;
      if (bus.trmt === 1'b1) begin
        trmt_cnt++;
        bytes.push_back(bus.tx_data);
        gaps.push_back(ncnt - last_rise);
        cur         = bus.tx_data;
        chk_en      = 1'b1;
        bus.tx_done = 1'b0;
        busy_cnt    = BYTE_CYC;
      end else if (busy_cnt > 0) begin
        if (!rst_n) chk_en = 1'b0;
        if (chk_en && (bus.tx_data !== cur)) stable_err++;
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.tx_done = 1'b1;
          rise_cnt++;
          last_rise = ncnt;
          chk_en    = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.clr_cmd_rdy === 1'b1) clr_cnt++;
      if (bus.tlm_gnt === 1'b1) gnt_cnt++;
      if (bus.op_vld === 1'b1) begin
        vld_run++;
        vld_total++;
      end else if (vld_run > 0) begin
        last_vld_len = vld_run;
        vld_run      = 0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bus.clr_cmd_rdy === 1'b1;
      1:       return bus.tlm_gnt === 1'b1;
      default: return bus.busy === 1'b0;
    endcase
  endfunction

  // sel: 0 clr_cmd_rdy, 1 tlm_gnt, 2 busy low
  task automatic wait_for(input int sel, input string tag, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cond(sel)) begin
        hit = 1'b1;
        break;
      end
    end
    chk({tag, " wait"}, 32'(hit), 32'd1);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (rd_idx < bytes.size()) ? 32'(bytes[rd_idx]) : 32'hFFFF_FFFF;
    chk(tag, obs, 32'(exp));
    rd_idx++;
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(negedge clk);
    bus.op_done = 1'b1;
    @(negedge clk);
    bus.op_done = 1'b0;
  endtask

  initial begin
    int v0, c0, g0, t0, r0, gi;
    bus.cmd_rdy  = 1'b0;
    bus.cmd      = 24'h0;
    bus.op_done  = 1'b0;
    bus.tlm_req  = 1'b0;
    bus.tlm_data = 16'h0;
    rst_n        = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("reset ctl", 32'({bus.clr_cmd_rdy, bus.trmt, bus.op_vld, bus.tlm_gnt, bus.busy}), 32'd0);
    chk("reset data", 32'({bus.tx_data, bus.op_code}), 32'd0);
    chk("reset op_data", 32'(bus.op_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // valid command, op_done after 10 cycles
    bus.cmd = 24'h0312AB; bus.cmd_rdy = 1'b1;
    wait_for(0, "t1 clr", 20);
    bus.cmd_rdy = 1'b0;
    chk("t1 op_vld", 32'(bus.op_vld), 32'd1);
    chk("t1 op_code", 32'(bus.op_code), 32'h03);
    chk("t1 op_data", 32'(bus.op_data), 32'h12AB);
    chk("t1 busy", 32'(bus.busy), 32'd1);
    pulse_done(10);
    chk("t1 op_vld fall", 32'(bus.op_vld), 32'd0);
    wait_for(2, "t1 idle", 100);
    chk("t1 vld len", 32'(last_vld_len), 32'd11);
    check_byte("t1 ack", 8'hA5);
    chk("t1 clr count", 32'(clr_cnt), 32'd1);

    // invalid opcodes 55 and 00, then boundary-valid 0F
    v0 = vld_total;
    bus.cmd = 24'h55AAE3; bus.cmd_rdy = 1'b1;
    wait_for(0, "t2 clr", 20);
    bus.cmd_rdy = 1'b0;
    chk("t2 op_code", 32'(bus.op_code), 32'h55);
    wait_for(2, "t2 idle", 100);
    check_byte("t2 nak", 8'hEE);
    bus.cmd = 24'h000001; bus.cmd_rdy = 1'b1;
    wait_for(0, "t2b clr", 20);
    bus.cmd_rdy = 1'b0;
    wait_for(2, "t2b idle", 100);
    check_byte("t2b nak", 8'hEE);
    chk("t2 no op_vld", 32'(vld_total), 32'(v0));
    bus.cmd = 24'h0F0001; bus.cmd_rdy = 1'b1;
    wait_for(0, "t2c clr", 20);
    bus.cmd_rdy = 1'b0;
    chk("t2c op_vld", 32'(bus.op_vld), 32'd1);
    pulse_done(0);
    wait_for(2, "t2c idle", 100);
    check_byte("t2c ack", 8'hA5);

    // timeout
    bus.cmd = 24'h0100FF; bus.cmd_rdy = 1'b1;
    wait_for(0, "t3 clr", 20);
    bus.cmd_rdy = 1'b0;
    wait_for(2, "t3 idle", 200);
    chk("t3 vld len", 32'(last_vld_len), 32'd50);
    check_byte("t3 nak", 8'hEE);

    // telemetry frame
    g0 = gnt_cnt; t0 = trmt_cnt; r0 = rise_cnt; gi = gaps.size();
    bus.tlm_data = 16'hBEEF; bus.tlm_req = 1'b1;
    wait_for(1, "t4 gnt", 20);
    bus.tlm_req = 1'b0;
    wait_for(2, "t4 idle", 200);
    chk("t4 gnt count", 32'(gnt_cnt - g0), 32'd1);
    check_byte("t4 hdr", 8'h5A);
    check_byte("t4 hi", 8'hBE);
    check_byte("t4 lo", 8'hEF);
    chk("t4 trmt count", 32'(trmt_cnt - t0), 32'd3);
    chk("t4 edge count", 32'(rise_cnt - r0), 32'd3);
    chk("t4 gap1", 32'((gaps.size() > gi + 2) ? gaps[gi+1] : -1), 32'd2);
    chk("t4 gap2", 32'((gaps.size() > gi + 2) ? gaps[gi+2] : -1), 32'd2);

    // simultaneous requests: command wins, pending command then loses to telemetry
    c0 = clr_cnt;
    bus.cmd = 24'h021234; bus.cmd_rdy = 1'b1;
    bus.tlm_data = 16'h1357; bus.tlm_req = 1'b1;
    wait_for(0, "t5 clr1", 20);
    bus.cmd_rdy = 1'b0;
    chk("t5 no gnt", 32'(bus.tlm_gnt), 32'd0);
    chk("t5 op_code1", 32'(bus.op_code), 32'h02);
    @(negedge clk);
    bus.cmd = 24'h040000; bus.cmd_rdy = 1'b1;
    pulse_done(3);
    wait_for(1, "t5 gnt", 100);
    bus.tlm_req = 1'b0;
    chk("t5 cmd held off", 32'(clr_cnt - c0), 32'd1);
    wait_for(0, "t5 clr2", 200);
    bus.cmd_rdy = 1'b0;
    chk("t5 op_code2", 32'(bus.op_code), 32'h04);
    pulse_done(2);
    wait_for(2, "t5 idle", 100);
    check_byte("t5 b0 ack", 8'hA5);
    check_byte("t5 b1 hdr", 8'h5A);
    check_byte("t5 b2 hi", 8'h13);
    check_byte("t5 b3 lo", 8'h57);
    check_byte("t5 b4 ack", 8'hA5);

    // reset during 2nd telemetry byte
    t0 = trmt_cnt;
    bus.tlm_data = 16'hC3C3; bus.tlm_req = 1'b1;
    wait_for(1, "t6 gnt", 20);
    bus.tlm_req = 1'b0;
    for (int i = 0; i < 100 && trmt_cnt < t0 + 2; i++) @(negedge clk);
    chk("t6 second byte", 32'(trmt_cnt >= t0 + 2), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6 reset ctl", 32'({bus.clr_cmd_rdy, bus.trmt, bus.op_vld, bus.tlm_gnt, bus.busy}), 32'd0);
    chk("t6 reset data", 32'({bus.tx_data, bus.op_code}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = trmt_cnt;
    repeat (40) @(negedge clk);
    chk("t6 no trmt", 32'(trmt_cnt - t0), 32'd0);
    chk("t6 busy", 32'(bus.busy), 32'd0);
    check_byte("t6 hdr", 8'h5A);
    check_byte("t6 hi", 8'hC3);
    bus.tlm_data = 16'h0102; bus.tlm_req = 1'b1;
    wait_for(1, "t7 gnt", 20);
    bus.tlm_req = 1'b0;
    wait_for(2, "t7 idle", 200);
    check_byte("t7 hdr", 8'h5A);
    check_byte("t7 hi", 8'h01);
    check_byte("t7 lo", 8'h02);
    chk("tx_data stable", 32'(stable_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
